// File: rtl/uart_program_loader.sv
// uart_program_loader: parses a length-prefixed program frame from the UART,
// writes little-endian words into the instruction ROM, checks an XOR checksum
// and releases the CPU only after a clean load.
module uart_program_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          MAX_WORDS      = 256,
  parameter int          TIMEOUT_CYCLES = 27000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rom_we,
  output logic [31:0] rom_address,
  output logic [31:0] rom_data,
  output logic        cpu_enable,
  output logic        done,
  output logic        error,
  output logic [2:0]  status
);

  localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CHECK  = 3'd3,
    S_RUN    = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [7:0]    len_lo;
  logic [7:0]    checksum;
  logic [15:0]   word_count;
  logic [15:0]   word_index;
  logic [1:0]    byte_index;
  logic [23:0]   word_buf;
  logic [TW-1:0] timer;
  logic [15:0]   len_full;
  logic          len_too_big;
  logic          last_word;
  logic          timed;
  logic          timeout;

  assign len_full    = {rx_data, len_lo};
  assign len_too_big = {16'd0, len_full} > MAX_W;
  assign last_word   = (byte_index == 2'd3) && (word_index == word_count - 16'd1);
  assign timed       = state inside {S_LEN_HI, S_DATA, S_CHECK};
  // A byte arriving on the final idle cycle takes priority over the timeout.
  assign timeout     = timed && !rx_valid && (timer == TW'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode from the current state and the incoming byte.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      S_IDLE, S_ERROR: begin
        if (rx_valid) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          if (len_too_big)           state_next = S_ERROR;
          else if (len_full == '0)   state_next = S_CHECK;
          else                       state_next = S_DATA;
        end else if (timeout) begin
          state_next = S_ERROR;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          if (last_word) state_next = S_CHECK;
        end else if (timeout) begin
          state_next = S_ERROR;
        end
      end
      S_CHECK: begin
        if (rx_valid)     state_next = (rx_data == checksum) ? S_RUN : S_ERROR;
        else if (timeout) state_next = S_ERROR;
      end
      S_RUN:   state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  // Inter-byte idle counter; restarts on every byte and on every state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                     timer <= '0;
    else if (!timed || rx_valid || state_next != state) timer <= '0;
    else                                           timer <= timer + 1'b1;
  end

  // Frame datapath: length capture, word assembly, checksum and ROM write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_lo      <= '0;
      checksum    <= '0;
      word_count  <= '0;
      word_index  <= '0;
      byte_index  <= '0;
      word_buf    <= '0;
      rom_we      <= 1'b0;
      rom_address <= '0;
      rom_data    <= '0;
    end else begin
      rom_we <= 1'b0;
      if (rx_valid) begin
        case (state)
          S_IDLE, S_ERROR: begin
            len_lo   <= rx_data;
            checksum <= rx_data;
          end
          S_LEN_HI: begin
            checksum   <= checksum ^ rx_data;
            word_count <= len_full;
            word_index <= '0;
            byte_index <= '0;
          end
          S_DATA: begin
            checksum   <= checksum ^ rx_data;
            word_buf   <= {rx_data, word_buf[23:8]};
            byte_index <= byte_index + 2'd1;
            if (byte_index == 2'd3) begin
              rom_we      <= 1'b1;
              rom_data    <= {rx_data, word_buf};
              rom_address <= BASE_ADDR + {14'd0, word_index, 2'b00};
              word_index  <= word_index + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign status     = state;
  assign cpu_enable = (state == S_RUN);
  assign done       = (state == S_RUN);
  assign error      = (state == S_ERROR);

endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: directed and randomized frames checked every cycle
// against a frame-level reference model, plus literal expectations.
module tb_uart_program_loader;

  localparam logic [31:0] BASE = 32'h0;
  localparam int          MAXW = 256;
  localparam int          TMO  = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rom_we;
  logic [31:0] rom_address;
  logic [31:0] rom_data;
  logic        cpu_enable;
  logic        done;
  logic        error;
  logic [2:0]  status;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  uart_program_loader #(
    .BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rom_we(rom_we), .rom_address(rom_address), .rom_data(rom_data),
    .cpu_enable(cpu_enable), .done(done), .error(error), .status(status)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: interprets the frame bytes seen so far
  logic [7:0]  frame[$];
  bit          m_run = 0, m_err = 0, m_we = 0;
  int          m_idle = 0;
  logic [31:0] m_addr = '0, m_data = '0;

  function automatic int m_phase();
    int n, nw;
    if (m_run) return 4;
    if (m_err) return 5;
    n = frame.size();
    if (n == 0) return 0;
    if (n == 1) return 1;
    nw = {frame[1], frame[0]};
    return (n - 2 < 4 * nw) ? 2 : 3;
  endfunction

  task automatic model_step();
    int ph, n, nw, d;
    logic [7:0] x;
    bit we_n;
    ph   = m_phase();
    we_n = 0;
    if (rx_valid && !m_run) begin
      if (m_err) begin
        m_err = 0;
        frame.delete();
      end
      frame.push_back(rx_data);
      m_idle = 0;
      n  = frame.size();
      nw = (n >= 2) ? int'({frame[1], frame[0]}) : 0;
      d  = n - 2;
      if (n == 2 && nw > MAXW) begin
        m_err = 1;
        frame.delete();
      end else if (n >= 3 && n == 4 * nw + 3) begin
        x = 8'h00;
        foreach (frame[i]) x ^= frame[i];
        if (x == 8'h00) m_run = 1;
        else            m_err = 1;
        frame.delete();
      end else if (d >= 4 && d % 4 == 0 && d <= 4 * nw) begin
        we_n   = 1;
        m_addr = BASE + 32'(4 * (d / 4 - 1));
        m_data = {frame[n-1], frame[n-2], frame[n-3], frame[n-4]};
      end
    end else if (ph >= 1 && ph <= 3) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_err  = 1;
        m_idle = 0;
        frame.delete();
      end
    end
    m_we = we_n;
  endtask

  // Model advances on the same edges as the DUT.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      frame.delete();
      m_run = 0; m_err = 0; m_we = 0; m_idle = 0;
      m_addr = '0; m_data = '0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison against the model, plus a write log for literal checks.
  int          wr_count = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  int          ph_cmp;
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      ph_cmp = m_phase();
      check("rom_we",      32'(rom_we),     32'(m_we));
      check("rom_address", rom_address,     m_addr);
      check("rom_data",    rom_data,        m_data);
      check("status",      32'(status),     32'(ph_cmp));
      check("done",        32'(done),       32'(ph_cmp == 4));
      check("cpu_enable",  32'(cpu_enable), 32'(ph_cmp == 4));
      check("error",       32'(error),      32'(ph_cmp == 5));
      if (rom_we === 1'b1) begin
        wr_count++;
        wr_addr = rom_address;
        wr_data = rom_data;
      end
    end
  end

  // ---------------- stimulus helpers
  logic [7:0] txq[$];

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_txq(input int gap);
    foreach (txq[i]) begin
      send_byte(txq[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_we"},     32'(rom_we),     32'd0);
    check({tag, "_addr"},   rom_address,     32'd0);
    check({tag, "_data"},   rom_data,        32'd0);
    check({tag, "_cpu"},    32'(cpu_enable), 32'd0);
    check({tag, "_done"},   32'(done),       32'd0);
    check({tag, "_err"},    32'(error),      32'd0);
    check({tag, "_status"}, 32'(status),     32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, nw, gap;
    logic [7:0] b, x;

    reset = 1'b1;
    #1;
    check_zero_outputs("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Single word, good checksum, back-to-back bytes.
    w0  = wr_count;
    txq = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    send_txq(0);
    idle(2);
    check("t1_writes", 32'(wr_count - w0), 32'd1);
    check("t1_addr",   wr_addr,            32'h0000_0000);
    check("t1_data",   wr_data,            32'h1234_5678);
    check("t1_status", 32'(status),        32'd4);
    check("t1_cpu",    32'(cpu_enable),    32'd1);

    // Two words on consecutive cycles.
    apply_reset();
    w0  = wr_count;
    txq = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h46};
    send_txq(0);
    idle(2);
    check("t2_writes", 32'(wr_count - w0), 32'd2);
    check("t2_addr",   wr_addr,            32'h0000_0004);
    check("t2_data",   wr_data,            32'h4433_2211);
    check("t2_status", 32'(status),        32'd4);

    // Empty program: RUN three cycles after the first byte.
    apply_reset();
    w0  = wr_count;
    txq = '{8'h00, 8'h00, 8'h00};
    send_txq(0);
    idle(1);
    check("t3_done",   32'(done),          32'd1);
    check("t3_cpu",    32'(cpu_enable),    32'd1);
    check("t3_writes", 32'(wr_count - w0), 32'd0);

    // Bad checksum, then recovery by a good frame without reset.
    apply_reset();
    w0  = wr_count;
    txq = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0A};
    send_txq(0);
    idle(2);
    check("t4_writes", 32'(wr_count - w0), 32'd1);
    check("t4_error",  32'(error),         32'd1);
    check("t4_cpu",    32'(cpu_enable),    32'd0);
    check("t4_status", 32'(status),        32'd5);
    txq = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    send_txq(0);
    idle(2);
    check("t4_recover_status", 32'(status), 32'd4);
    check("t4_recover_error",  32'(error),  32'd0);

    // Oversized length.
    apply_reset();
    w0 = wr_count;
    send_byte(8'h01);
    send_byte(8'h01);
    idle(1);
    check("t5_status", 32'(status),        32'd5);
    check("t5_writes", 32'(wr_count - w0), 32'd0);

    // Timeout after a data byte.
    apply_reset();
    txq = '{8'h01, 8'h00, 8'h78};
    send_txq(0);
    idle(TMO + 1);
    check("t6_timeout_status", 32'(status), 32'd5);

    // Byte on the last idle cycle prevents the timeout.
    apply_reset();
    send_txq(0);
    idle(TMO - 1);
    send_byte(8'h56);
    idle(1);
    check("t6_saved_status", 32'(status), 32'd2);
    txq = '{8'h34, 8'h12, 8'h09};
    send_txq(0);
    idle(2);
    check("t6_saved_run", 32'(status), 32'd4);

    // Reset in the middle of a word, then a fresh load from BASE.
    apply_reset();
    txq = '{8'h01, 8'h00, 8'h78, 8'h56};
    send_txq(0);
    @(negedge clock);
    rx_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check_zero_outputs("t7_reset");
    @(negedge clock);
    reset = 1'b0;
    txq = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
    send_txq(0);
    idle(2);
    check("t7_addr",   wr_addr,     BASE);
    check("t7_data",   wr_data,     32'hDEAD_BEEF);
    check("t7_status", 32'(status), 32'd4);

    // Randomized frames: gaps, timeouts, corrupt checksums, oversize lengths.
    for (int it = 0; it < 40; it++) begin
      if (m_run || $urandom_range(0, 3) == 0) apply_reset();
      nw = $urandom_range(0, 5);
      if ($urandom_range(0, 7) == 0) nw = $urandom_range(MAXW + 1, MAXW + 40);
      txq.delete();
      txq.push_back(8'(nw));
      txq.push_back(8'(nw >> 8));
      if (nw <= MAXW) begin
        x = txq[0] ^ txq[1];
        for (int k = 0; k < 4 * nw; k++) begin
          b = 8'($urandom);
          txq.push_back(b);
          x ^= b;
        end
        if ($urandom_range(0, 4) == 0) x ^= 8'(1 << $urandom_range(0, 7));
        txq.push_back(x);
      end
      foreach (txq[i]) begin
        send_byte(txq[i]);
        gap = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
        if ($urandom_range(0, 29) == 0) gap = TMO + 2;
        if (gap > 0) idle(gap);
      end
      idle($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) begin
        send_byte(8'($urandom));
        idle(1);
      end
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
Sits between the UART byte receiver and the CPU instruction ROM on the Nano 9k build. It consumes received bytes and parses a length-prefixed program frame. It assembles little-endian 32-bit words, writes them sequentially into ROM, and verifies an XOR checksum. On success it releases the CPU via cpu_enable; on any fault it holds the CPU disabled and flags an error.

Parameters:
BASE_ADDR, 0, byte address of the first ROM word written
MAX_WORDS, 256, largest accepted word count; larger frames are rejected
TIMEOUT_CYCLES, 27000000, inter-byte idle limit while mid-frame (1 s at 27 MHz)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_data  in  8  received byte from UART receiver
rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
rom_we  out  1  one-cycle ROM write strobe
rom_address  out  32  byte address of the word being written
rom_data  out  32  word being written
cpu_enable  out  1  high = CPU may run
done  out  1  high after a frame loads with a good checksum
error  out  1  high after a checksum, length or timeout fault
status  out  3  current state encoding, for LEDs

Behaviour:
- Frame format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4*N data bytes: each word is little-endian (byte0 = bits 7:0).
  - One checksum byte: XOR of every preceding frame byte, length bytes included.
- Reset (async, any state): all outputs 0; state IDLE; word index, byte index, checksum and timer cleared. Reset mid-load abandons the frame. ROM contents already written are not touched.
- States and encodings: IDLE=0, LEN_HI=1, DATA=2, CHECK=3, RUN=4, ERROR=5.
- IDLE:
  - rx_valid: latch LEN_LO, checksum = byte, go to LEN_HI.
- LEN_HI:
  - rx_valid: form N and fold the byte into the checksum.
  - N > MAX_WORDS: go to ERROR.
  - N == 0: go to CHECK.
  - Otherwise: go to DATA.
- DATA:
  - Each accepted byte shifts into the word buffer at byte index 0..3 and XORs into the checksum.
  - On byte index 3: register rom_data = assembled word and rom_address = BASE_ADDR + 4*word_index.
  - rom_we pulses high exactly the cycle after the 4th byte is accepted.
  - Then word_index increments and byte index wraps to 0.
  - A byte arriving in the same cycle as rom_we is accepted normally; back-to-back bytes every cycle are legal.
  - After word N-1 completes, go to CHECK.
- CHECK:
  - Next byte equal to the running checksum: go to RUN.
  - Otherwise: go to ERROR.
- RUN: cpu_enable=1, done=1. rx_valid is ignored; leaving RUN requires reset.
- ERROR:
  - cpu_enable=0, error=1.
  - Next rx_valid is treated as a new LEN_LO: error clears, go to LEN_HI.
- Timeout:
  - The idle counter is active only in LEN_HI, DATA and CHECK.
  - It clears on every accepted byte and on each state entry.
  - Reaching TIMEOUT_CYCLES-1 with no byte: go to ERROR next cycle.
  - A byte arriving in that same cycle wins; no timeout occurs.
- Hold rules:
  - cpu_enable stays 0 in every state except RUN.
  - rom_address and rom_data hold their last values between writes.

Test Plan:
- Frame 01 00 78 56 34 12 09 -> one rom_we pulse with rom_address=0x00000000 and rom_data=0x12345678, one cycle after byte 0x12; then done=1, cpu_enable=1, status=4.
- Frame 02 00 + 8 data bytes sent on consecutive cycles, correct checksum -> two rom_we pulses at addresses 0x0 and 0x4 with correct words; ends in RUN.
- Frame 00 00 00 -> no rom_we; done=1 and cpu_enable=1 three cycles after the first byte.
- Frame 01 00 78 56 34 12 0A (bad checksum) -> word still written, then error=1, cpu_enable=0, status=5; a following good frame clears error and ends in RUN.
- Length 01 01 (257 > MAX_WORDS) -> ERROR right after the second byte, no rom_we. Separately, with TIMEOUT_CYCLES=16, stall 16 cycles after a data byte -> ERROR; a byte arriving on cycle 16 instead prevents the timeout.
- Assert reset during DATA, after two bytes of a word -> all outputs 0 immediately, status=0; a fresh complete frame then loads correctly from BASE_ADDR.
